periph_rx_arbiter: RTL and testbench
====================================

Name: periph_rx_arbiter

Overview:
- Merges the rx streams of all reconfigurable peripheral slots into the single shared upstream (device-to-host) USB FIFO.
- Each slot gets a small elastic buffer. A round-robin scheduler with a per-grant burst limit drains the buffers.
- Each popped word is tagged with its slot's peripheral address to rebuild a full usb_packet_width packet.
- Sits between the peripheral wrappers' rx ports and the USB-side TX FIFO write port.

Parameters:
- NUM_PERIPHS, default num_peripherals (package), number of peripheral slots; power of two, ≥2.
- ADDR_W, default periph_address_width, tag width; 2**ADDR_W ≥ NUM_PERIPHS.
- DATA_W, default usb_packet_width-periph_address_width, payload width per word.
- BUF_DEPTH, default 4, per-slot buffer depth; power of two, ≥2.
- BURST_LEN, default 8, maximum words popped per grant; ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  NUM_PERIPHS*DATA_W  slot i payload at bits [i*DATA_W +: DATA_W].
- rx_valid  input  NUM_PERIPHS  slot i write strobe.
- rx_fifo_full  output  NUM_PERIPHS  slot i buffer full; feeds that wrapper's rx_fifo_full.
- usb_wr_data  output  usb_packet_width  {ADDR_W'(slot), payload}, slot tag in MSBs.
- usb_wr_en  output  1  one-cycle write strobe to the shared FIFO.
- usb_full  input  1  shared FIFO full.
- overflow  output  NUM_PERIPHS  sticky: slot i wrote while its buffer was full and no pop occurred.
- overflow_clr  input  1  clears all overflow bits.
- idle  output  1  all buffers empty, FSM in IDLE, no write in flight.

Behaviour:
- Reset (rst=0, async) values: buffers empty, rx_fifo_full=0, usb_wr_en=0, usb_wr_data=0, overflow=0, FSM=IDLE, rr_ptr=0, burst_cnt=0, idle=1.
- Per-slot buffer: first-word-fall-through register array plus count.
  - Push when rx_valid[i] and (count<BUF_DEPTH or pop[i] in the same cycle).
  - rx_fifo_full[i] = (count==BUF_DEPTH), combinational from count.
  - Simultaneous push and pop at full: both take effect; count unchanged; no overflow.
  - Push at full with no pop: word dropped, overflow[i] set. Set dominates overflow_clr in the same cycle.
  - Pointers wrap modulo BUF_DEPTH.
- FSM IDLE:
  - If any buffer is non-empty, grant = first non-empty slot searching from rr_ptr upward with wrap. Latch grant, burst_cnt=0, go SERVE.
  - Otherwise stay in IDLE.
- FSM SERVE:
  - pop[grant] = buffer non-empty and !usb_full.
  - On pop: usb_wr_en<=1 and usb_wr_data<={grant, head} on the next edge (1-cycle latency); burst_cnt++.
  - Leave for IDLE when (pop and (burst_cnt==BURST_LEN-1 or count==1 with no same-cycle push)), or when the buffer is empty. Set rr_ptr=grant+1 mod NUM_PERIPHS.
  - usb_full stalls SERVE indefinitely; the grant is held and burst_cnt is frozen.
- Arbitration cost: one bubble cycle in IDLE between grants. Sustained throughput is BURST_LEN/(BURST_LEN+1) words per cycle.
- Fairness: a continuously busy slot gets at most BURST_LEN words before every other non-empty slot is served once.
- usb_full is sampled in the pop cycle. A write registered in that cycle is issued the next cycle regardless of usb_full. The shared FIFO therefore must assert full with ≥1 slot of slack (programmable-full).
- Ordering: words from one slot leave in arrival order. There is no ordering guarantee across slots.
- idle = (FSM==IDLE) and all counts==0 and !usb_wr_en.
- Reset mid-burst: pending data discarded, all state returns to reset values asynchronously.

Decomposition:
- lycan_globals gains num_peripherals and a typedef for the tagged packet struct {logic [periph_address_width-1:0] addr; logic [DATA_W-1:0] data;}.
- FSM state enum {IDLE, SERVE} is local.
- One sub-module: periph_rx_buf, the per-slot FWFT buffer with count, full, empty and overflow, instantiated NUM_PERIPHS times via generate.
- Round-robin search is a function inside the top.

Test Plan:
- Single slot: slot 2 pushes 0x0A1, 0x0A2, 0x0A3 on consecutive cycles, usb_full=0. Expect usb_wr_en for 3 cycles, data {2,0x0A1}, {2,0x0A2}, {2,0x0A3} in order. First write 2 cycles after the first push (push→IDLE grant→pop→register). idle returns to 1.
- Round-robin and burst, BURST_LEN=2: slots 0 and 1 each hold 4 words. Expect output slot sequence 0,0,1,1,0,0,1,1 with one bubble cycle between bursts.
- Backpressure: usb_full=1 during SERVE of slot 3 for 5 cycles. Expect usb_wr_en=0 after the in-flight write, grant and burst_cnt held. On release, writes resume with no loss or duplication.
- Overflow: BUF_DEPTH=4, usb_full=1, slot 1 pushes 5 words. Expect rx_fifo_full[1]=1 after the 4th push, 5th word dropped, overflow[1]=1. Then overflow_clr=1 clears it; the 4 stored words drain in order.
- Full push+pop: slot 0 full, usb_full=0, rx_valid[0]=1 in the pop cycle. Expect the word accepted, count stays 4, overflow[0]=0.
- Async reset mid-burst: drive rst=0 between edges while slot 2 is being served. Expect usb_wr_en, rx_fifo_full and overflow all 0 immediately and idle=1. After release, no stale words are emitted.

Source files
------------

// File: rtl/periph_rx_arbiter_pkg.sv
// Shared sizing for the peripheral rx merge path.
//   usb_packet_width      : width of one word in the shared upstream USB FIFO
//   periph_address_width  : width of the slot tag carried in the packet MSBs
//   num_peripherals       : number of reconfigurable peripheral slots
//   periph_packet_t       : tagged upstream packet {addr, data}
package periph_rx_arbiter_pkg;

    localparam int usb_packet_width     = 16;
    localparam int periph_address_width = 4;
    localparam int num_peripherals      = 4;
    localparam int periph_data_width    = usb_packet_width - periph_address_width;

    typedef struct packed {
        logic [periph_address_width-1:0] addr;
        logic [periph_data_width-1:0]    data;
    } periph_packet_t;

endpackage

// File: rtl/periph_rx_buf.sv
// Per-slot first-word-fall-through elastic buffer with occupancy count.
//   clk, rst      : system clock, asynchronous active-low reset
//   push_i/data_i : write strobe and payload from the peripheral wrapper
//   pop_i         : consume the head word (only asserted while non-empty)
//   ovf_clr_i     : clear the sticky overflow flag
//   head_o        : current head word (valid while !empty_o)
//   count_o       : words stored, 0..DEPTH
//   full_o/empty_o: occupancy flags, combinational from the count
//   overflow_o    : sticky, a write arrived while full and nothing popped
module periph_rx_buf
    import periph_rx_arbiter_pkg::*;
#(
    parameter int DATA_W = periph_data_width,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    input  logic                     ovf_clr_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q;
    logic              do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign head_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // A pop in the same cycle frees the slot the incoming word needs.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            // A new drop wins over a clear in the same cycle.
            if (push_i && full_o && !pop_i) ovf_q <= 1'b1;
            else if (ovf_clr_i)             ovf_q <= 1'b0;
        end
    end

    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Merges the rx streams of all peripheral slots into the shared upstream
// USB FIFO. Each slot has a small FWFT buffer; a round-robin scheduler with
// a per-grant burst limit drains them and tags each word with its slot.
//   clk, rst       : system clock, asynchronous active-low reset
//   rx_data        : slot i payload at [i*DATA_W +: DATA_W]
//   rx_valid       : slot i write strobe
//   rx_fifo_full   : slot i buffer full
//   usb_wr_data    : {slot tag, payload}, tag in the MSBs
//   usb_wr_en      : one-cycle write strobe to the shared FIFO
//   usb_full       : shared FIFO (programmable) full
//   overflow       : sticky per-slot drop flag
//   overflow_clr   : clears all overflow flags
//   idle           : nothing buffered, nothing granted, no write in flight
//
// state  | meaning
// IDLE   | no grant held; picks the next non-empty slot from rr_ptr (one bubble)
// SERVE  | draining the granted slot, at most BURST_LEN words, stalls on usb_full
module periph_rx_arbiter
    import periph_rx_arbiter_pkg::*;
#(
    parameter int NUM_PERIPHS = num_peripherals,
    parameter int ADDR_W      = periph_address_width,
    parameter int DATA_W      = usb_packet_width - periph_address_width,
    parameter int BUF_DEPTH   = 4,
    parameter int BURST_LEN   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PERIPHS*DATA_W-1:0] rx_data,
    input  logic [NUM_PERIPHS-1:0]        rx_valid,
    output logic [NUM_PERIPHS-1:0]        rx_fifo_full,
    output logic [ADDR_W+DATA_W-1:0]      usb_wr_data,
    output logic                          usb_wr_en,
    input  logic                          usb_full,
    output logic [NUM_PERIPHS-1:0]        overflow,
    input  logic                          overflow_clr,
    output logic                          idle
);

    localparam int SEL_W = $clog2(NUM_PERIPHS);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int BC_W  = $clog2(BURST_LEN + 1);

    typedef enum logic {ST_IDLE, ST_SERVE} state_t;

    state_t                      state_q;
    logic [SEL_W-1:0]            grant_q;
    logic [SEL_W-1:0]            rr_ptr_q;
    logic [BC_W-1:0]             burst_cnt_q;
    logic                        usb_wr_en_q;
    logic [ADDR_W+DATA_W-1:0]    usb_wr_data_q;

    logic [DATA_W-1:0]           head  [NUM_PERIPHS];
    logic [CNT_W-1:0]            count [NUM_PERIPHS];
    logic [NUM_PERIPHS-1:0]      empty;
    logic [NUM_PERIPHS-1:0]      req;
    logic [NUM_PERIPHS-1:0]      pop;
    logic                        pop_any;
    logic                        burst_done;
    logic                        last_word;

    // First requesting slot at or after start, wrapping around.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_PERIPHS-1:0] r,
                                                 input logic [SEL_W-1:0]       start);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            idx = start + SEL_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    for (genvar g = 0; g < NUM_PERIPHS; g++) begin : g_buf
        periph_rx_buf #(
            .DATA_W (DATA_W),
            .DEPTH  (BUF_DEPTH)
        ) u_buf (
            .clk        (clk),
            .rst        (rst),
            .push_i     (rx_valid[g]),
            .data_i     (rx_data[g*DATA_W +: DATA_W]),
            .pop_i      (pop[g]),
            .ovf_clr_i  (overflow_clr),
            .head_o     (head[g]),
            .count_o    (count[g]),
            .full_o     (rx_fifo_full[g]),
            .empty_o    (empty[g]),
            .overflow_o (overflow[g])
        );
    end

    assign req = ~empty;

    always_comb begin
        pop = '0;
        if (state_q == ST_SERVE && !empty[grant_q] && !usb_full) pop[grant_q] = 1'b1;
    end

    assign pop_any    = |pop;
    assign burst_done = (burst_cnt_q == BC_W'(BURST_LEN - 1));
    // Popping the only word, with nothing arriving behind it, empties the slot.
    assign last_word  = (count[grant_q] == CNT_W'(1)) && !rx_valid[grant_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            usb_wr_en_q   <= 1'b0;
            usb_wr_data_q <= '0;
        end else begin
            usb_wr_en_q <= pop_any;
            if (pop_any) usb_wr_data_q <= {ADDR_W'(grant_q), head[grant_q]};
            unique case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q     <= rr_pick(req, rr_ptr_q);
                        burst_cnt_q <= '0;
                        state_q     <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (pop_any) begin
                        burst_cnt_q <= burst_cnt_q + BC_W'(1);
                        if (burst_done || last_word) begin
                            state_q  <= ST_IDLE;
                            rr_ptr_q <= grant_q + SEL_W'(1);
                        end
                    end else if (empty[grant_q]) begin
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= grant_q + SEL_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign usb_wr_en   = usb_wr_en_q;
    assign usb_wr_data = usb_wr_data_q;
    assign idle        = (state_q == ST_IDLE) && (&empty) && !usb_wr_en_q;

endmodule

// File: tb/tb_periph_rx_arbiter.sv
module tb_periph_rx_arbiter;
    import periph_rx_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int AW = 4;
    localparam int DW = 12;
    localparam int BD = 4;
    localparam int BL = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP*DW-1:0]  rx_data = '0;
    logic [NP-1:0]     rx_valid = '0;
    logic [NP-1:0]     rx_fifo_full;
    logic [AW+DW-1:0]  usb_wr_data;
    logic              usb_wr_en;
    logic              usb_full = 1'b0;
    logic [NP-1:0]     overflow;
    logic              overflow_clr = 1'b0;
    logic              idle;

    periph_rx_arbiter #(
        .NUM_PERIPHS (NP),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .BUF_DEPTH   (BD),
        .BURST_LEN   (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_fifo_full (rx_fifo_full),
        .usb_wr_data  (usb_wr_data),
        .usb_wr_en    (usb_wr_en),
        .usb_full     (usb_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW+DW-1:0] pkt;
        bit               gap_chk;
        bit               first;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] m_q [NP][$];
    int            m_ptr = 0;
    int            pl_cnt [NP];
    int            wr_log[$];
    int            last_wr = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every write must match the next expected packet.
    always @(negedge clk) begin
        if (rst && usb_wr_en) begin
            wr_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got 0x%0h, expected no write", usb_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_data", usb_wr_data, mon_e.pkt);
                if (mon_e.gap_chk) check("wr_gap", cyc - last_wr, mon_e.first ? 2 : 1);
            end
            last_wr = cyc;
        end
    end

    // Reference: visit non-empty slots round-robin from m_ptr, at most BL words each.
    task automatic model_drain(input bit gchk);
        bit   any;
        bit   first_all = 1'b1;
        int   g;
        int   k;
        exp_t e;
        forever begin
            any = 1'b0;
            for (int i = 0; i < NP; i++) if (m_q[i].size() != 0) any = 1'b1;
            if (!any) break;
            g = 0;
            for (int i = 0; i < NP; i++) begin
                int s = (m_ptr + i) % NP;
                if (m_q[s].size() != 0) begin
                    g = s;
                    break;
                end
            end
            k = (m_q[g].size() < BL) ? m_q[g].size() : BL;
            for (int j = 0; j < k; j++) begin
                e.pkt     = {AW'(g), m_q[g].pop_front()};
                e.gap_chk = gchk && !first_all;
                e.first   = (j == 0);
                exp_q.push_back(e);
                first_all = 1'b0;
            end
            m_ptr = (g + 1) % NP;
        end
    endtask

    // Load pl_cnt[s] random words into each slot at once while the USB side is full.
    task automatic preload();
        logic [DW-1:0] d;
        usb_full = 1'b1;
        for (int k = 0; k < BD; k++) begin
            @(negedge clk);
            rx_valid = '0;
            for (int s = 0; s < NP; s++) begin
                if (k < pl_cnt[s]) begin
                    d = DW'($urandom);
                    rx_valid[s] = 1'b1;
                    rx_data[s*DW +: DW] = d;
                    m_q[s].push_back(d);
                end
            end
        end
        @(negedge clk);
        rx_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input bit toggle, input string tag);
        int n = 0;
        usb_full = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            if (exp_q.size() == 0 && idle) break;
            usb_full = toggle ? ($urandom_range(0, 3) == 0) : 1'b0;
            n++;
        end
        usb_full = 1'b0;
        check({tag, "_timeout"}, n < 400, 1);
        check({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    task automatic wait_first_write(input string tag);
        int n = 0;
        while (n < 20 && !usb_wr_en) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_first_write"}, usb_wr_en, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int lat;
        logic [DW-1:0] d;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wr_en", usb_wr_en, 0);
        check("rst_wr_data", usb_wr_data, 0);
        check("rst_full", rx_fifo_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_idle", idle, 1);
        rst = 1'b1;
        @(negedge clk);

        // Single slot: slot 2 pushes three consecutive words
        m_q[2].push_back(12'h0A1);
        m_q[2].push_back(12'h0A2);
        m_q[2].push_back(12'h0A3);
        model_drain(1'b0);
        wr_log.delete();
        rx_valid[2] = 1'b1;
        rx_data[2*DW +: DW] = 12'h0A1;
        p = cyc + 1;
        @(negedge clk);
        rx_data[2*DW +: DW] = 12'h0A2;
        @(negedge clk);
        rx_data[2*DW +: DW] = 12'h0A3;
        @(negedge clk);
        rx_valid = '0;
        drain(1'b0, "single");
        check("single_writes", wr_log.size(), 3);
        lat = (wr_log.size() > 0) ? wr_log[0] - p : -1;
        check("single_latency", lat, 2);
        check("single_idle", idle, 1);

        // Round robin with burst limit: slots 0 and 1 hold four words each
        pl_cnt = '{4, 4, 0, 0};
        preload();
        model_drain(1'b1);
        drain(1'b0, "rr");

        // Backpressure while slot 3 is served
        pl_cnt = '{0, 0, 0, 4};
        preload();
        model_drain(1'b0);
        usb_full = 1'b0;
        wait_first_write("bp");
        usb_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_wr_en", usb_wr_en, 0);
            check("bp_idle", idle, 0);
        end
        drain(1'b0, "bp");

        // Overflow on slot 1 with the USB side full
        usb_full = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            d = DW'($urandom);
            rx_valid[1] = 1'b1;
            rx_data[1*DW +: DW] = d;
            if (k <= BD) m_q[1].push_back(d);
            @(negedge clk);
            rx_valid = '0;
            check("ovf_full", rx_fifo_full[1], k >= BD);
            check("ovf_flag", overflow[1], k > BD);
        end
        rx_valid[1] = 1'b1;
        rx_data[1*DW +: DW] = DW'($urandom);
        overflow_clr = 1'b1;
        @(negedge clk);
        rx_valid = '0;
        check("ovf_set_wins", overflow[1], 1);
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        model_drain(1'b0);
        drain(1'b0, "ovf");

        // Push and pop together while slot 0 is full
        pl_cnt = '{4, 0, 0, 0};
        preload();
        check("pp_full_before", rx_fifo_full[0], 1);
        d = DW'($urandom);
        m_q[0].push_back(d);
        model_drain(1'b0);
        usb_full = 1'b0;
        rx_valid[0] = 1'b1;
        rx_data[0 +: DW] = d;
        @(negedge clk);
        rx_valid = '0;
        check("pp_popped", usb_wr_en, 1);
        check("pp_full_after", rx_fifo_full[0], 1);
        check("pp_no_ovf", overflow[0], 0);
        drain(1'b0, "pp");

        // Randomized rounds, alternating free-running and random backpressure
        for (int r = 0; r < 8; r++) begin
            bit tog = r[0];
            int sum = 0;
            for (int s = 0; s < NP; s++) begin
                pl_cnt[s] = $urandom_range(0, BD);
                sum += pl_cnt[s];
            end
            if (sum == 0) pl_cnt[r % NP] = 1;
            preload();
            model_drain(!tog);
            drain(tog, "rand");
        end

        // Asynchronous reset in the middle of serving slot 2
        pl_cnt = '{0, 0, 4, 0};
        preload();
        @(negedge clk);
        rx_valid[2] = 1'b1;
        rx_data[2*DW +: DW] = DW'($urandom);
        @(negedge clk);
        rx_valid = '0;
        check("ar_pre_ovf", overflow[2], 1);
        check("ar_pre_full", rx_fifo_full[2], 1);
        model_drain(1'b0);
        usb_full = 1'b0;
        wait_first_write("ar");
        #2;
        rst = 1'b0;
        #1;
        check("ar_wr_en", usb_wr_en, 0);
        check("ar_full", rx_fifo_full, 0);
        check("ar_ovf", overflow, 0);
        check("ar_idle", idle, 1);
        exp_q.delete();
        for (int s = 0; s < NP; s++) m_q[s].delete();
        m_ptr = 0;
        wr_log.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("ar_no_stale", wr_log.size(), 0);
        check("ar_idle_after", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
